// File: rtl/cru_pkg.sv
// Shared definitions for the CRU bit-serial initiator.
//   cru_state_t : transfer sequencer states
//   CRU_AW      : CRU bit-address width
//   CRU_DW      : transfer data width
//   eff_cnt()   : maps the 4-bit count field to 1..16 (0 means 16)
package cru_pkg;

  localparam int unsigned CRU_AW = 15;
  localparam int unsigned CRU_DW = 16;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    STRB,
    HOLD,
    SAMP,
    FIN
  } cru_state_t;

  function automatic logic [4:0] eff_cnt(input logic [3:0] c);
    return (c == 4'd0) ? 5'd16 : {1'b0, c};
  endfunction

endpackage

// File: rtl/cru_master.sv
// Bit-serial CRU initiator performing LDCR (write) and STCR (read) transfers
// of 1..16 bits, LSB first, one bit address per bit.
// Optional feature macro: CRU_BYTE_EN (byte-aligned data for counts 1..8).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, op_ld      request (IDLE only); 1=LDCR, 0=STCR
//   base, cnt, wdata  first bit address, bit count (0=16), LDCR source word
//   rdata             STCR result, valid with done
//   busy, done        transfer in progress; one-cycle end pulse
//   ab, cruclk        CRU address {bit_addr,0}; active-low write strobe
//   cruout, cruin     write data bit; read data bit from responder
//   cru_cyc           CRU bus cycle in progress
module cru_master
  import cru_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned STRB_CYC  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_ld,
  input  logic [14:0] base,
  input  logic [3:0]  cnt,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] ab,
  output logic        cruclk,
  output logic        cruout,
  input  logic        cruin,
  output logic        cru_cyc
);

  cru_state_t          state;
  logic                op_r;
  logic [CRU_AW-1:0]   base_r;
  logic [4:0]          n_r;
  logic [4:0]          idx;
  logic [CRU_DW-1:0]   src;
  logic [CRU_DW-1:0]   sh;
  logic [2:0]          tmr;

  logic [CRU_DW-1:0]   wsrc_c;
  logic [CRU_DW-1:0]   res_c;
  logic [CRU_DW-1:0]   rdata_c;
  logic                last_c;
  logic [CRU_AW-1:0]   nxt_addr_c;

`ifdef CRU_BYTE_EN
  logic                byte_c;
  logic                byte_r;
`endif

  // Source word alignment, sampled result word, next-bit address.
  always_comb begin
`ifdef CRU_BYTE_EN
    byte_c  = (cnt != 4'd0) && (cnt <= 4'd8);
    wsrc_c  = byte_c ? {8'h00, wdata[15:8]} : wdata;
`else
    wsrc_c  = wdata;
`endif
    res_c              = sh;
    res_c[idx[3:0]]    = cruin;
`ifdef CRU_BYTE_EN
    rdata_c = byte_r ? {res_c[7:0], 8'h00} : res_c;
`else
    rdata_c = res_c;
`endif
    last_c     = (idx == (n_r - 5'd1));
    nxt_addr_c = base_r + CRU_AW'(idx) + CRU_AW'(1);
  end

  // Sequencer with inline shift/count datapath; outputs registered for the state entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_r    <= 1'b0;
      base_r  <= '0;
      n_r     <= 5'd0;
      idx     <= 5'd0;
      src     <= '0;
      sh      <= '0;
      tmr     <= 3'd0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ab      <= '0;
      cruclk  <= 1'b1;
      cruout  <= 1'b0;
      cru_cyc <= 1'b0;
`ifdef CRU_BYTE_EN
      byte_r  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r    <= op_ld;
            base_r  <= base;
            n_r     <= eff_cnt(cnt);
            idx     <= 5'd0;
            sh      <= '0;
            src     <= wsrc_c;
            tmr     <= 3'(SETUP_CYC - 1);
            ab      <= {base, 1'b0};
            cruout  <= wsrc_c[0];
            cruclk  <= 1'b1;
            busy    <= 1'b1;
            cru_cyc <= 1'b1;
            state   <= ADDR;
`ifdef CRU_BYTE_EN
            byte_r  <= byte_c;
`endif
          end
        end
        ADDR: begin
          if (tmr != 3'd0) begin
            tmr <= tmr - 3'd1;
          end else if (op_r) begin
            cruclk <= 1'b0;
            tmr    <= 3'(STRB_CYC - 1);
            state  <= STRB;
          end else begin
            state <= SAMP;
          end
        end
        STRB: begin
          if (tmr != 3'd0) begin
            tmr <= tmr - 3'd1;
          end else begin
            cruclk <= 1'b1;
            state  <= HOLD;
          end
        end
        HOLD, SAMP: begin
          // SAMP captures cruin at this edge; the final word includes it.
          if (!op_r) sh <= res_c;
          if (last_c) begin
            if (!op_r) rdata <= rdata_c;
            done    <= 1'b1;
            busy    <= 1'b0;
            cru_cyc <= 1'b0;
            ab      <= '0;
            cruout  <= 1'b0;
            state   <= FIN;
          end else begin
            idx    <= idx + 5'd1;
            src    <= {1'b0, src[15:1]};
            cruout <= src[1];
            ab     <= {nxt_addr_c, 1'b0};
            tmr    <= 3'(SETUP_CYC - 1);
            state  <= ADDR;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
